// File: rtl/cpx_arb_pkg.sv
// Shared constants for the cpx_multiply arbiter: requester tags and a clog2 helper.
package cpx_arb_pkg;

    localparam int unsigned TAG_W = 1;

    typedef logic [TAG_W-1:0] tag_t;

    localparam tag_t TAG_REQ0 = 1'b0;
    localparam tag_t TAG_REQ1 = 1'b1;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2_f(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cpx_arb_tag_fifo.sv
// Owner-tag FIFO: one entry per product in flight, simultaneous push/pop, registered flags.
module cpx_arb_tag_fifo
    import cpx_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CW    = clog2_f(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  tag_t          push_tag,
    input  logic          pop,
    output tag_t          head_tag,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    localparam int unsigned AW = clog2_f(DEPTH);

    tag_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;
    logic [CW-1:0] count_nxt;

    assign push_ok  = push && !full;
    assign pop_ok   = pop && !empty;
    assign head_tag = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)      count_nxt = count + CW'(1);
        else if (pop_ok && !push_ok) count_nxt = count - CW'(1);
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok) rd_ptr <= rd_ptr + AW'(1);
            count <= count_nxt;
            empty <= (count_nxt == '0);
            full  <= (count_nxt == CW'(DEPTH));
        end
    end

endmodule

// File: rtl/cpx_multiply_arbiter.sv
// Round-robin sharing of one cpx_multiply between two requesters, products routed back by owner tag.
// Optional statistics counters: define CPX_ARB_STATS_EN.
module cpx_multiply_arbiter
    import cpx_arb_pkg::*;
#(
    parameter int unsigned X_BITS       = 12,
    parameter int unsigned Y_BITS       = 12,
    parameter int unsigned OUT_BITS     = 25,
    parameter int unsigned MAX_OUTSTAND = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [X_BITS-1:0]   req0_xi,
    input  logic [X_BITS-1:0]   req0_xq,
    input  logic [Y_BITS-1:0]   req0_yi,
    input  logic [Y_BITS-1:0]   req0_yq,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [X_BITS-1:0]   req1_xi,
    input  logic [X_BITS-1:0]   req1_xq,
    input  logic [Y_BITS-1:0]   req1_yi,
    input  logic [Y_BITS-1:0]   req1_yq,
    output logic                mul_valid,
    input  logic                mul_ready,
    output logic [X_BITS-1:0]   mul_xi,
    output logic [X_BITS-1:0]   mul_xq,
    output logic [Y_BITS-1:0]   mul_yi,
    output logic [Y_BITS-1:0]   mul_yq,
    input  logic                prod_valid,
    output logic                prod_ready,
    input  logic [OUT_BITS-1:0] prod_i,
    input  logic [OUT_BITS-1:0] prod_q,
    output logic                res0_valid,
    input  logic                res0_ready,
    output logic                res1_valid,
    input  logic                res1_ready,
    output logic [OUT_BITS-1:0] res_i,
    output logic [OUT_BITS-1:0] res_q
`ifdef CPX_ARB_STATS_EN
    ,
    output logic [31:0]         grant_cnt0,
    output logic [31:0]         grant_cnt1,
    output logic [31:0]         stall_cnt
`endif
);

    localparam int unsigned CNT_W = clog2_f(MAX_OUTSTAND) + 1;

    logic             slot_free;
    logic             can_issue;
    logic             gnt_valid;
    tag_t             gnt;
    tag_t             rr_ptr;
    logic             accept;
    tag_t             head_tag;
    logic             fifo_empty;
    logic             fifo_full;
    logic [CNT_W-1:0] outstanding;
    logic             sel_ready;
    logic             pop;

    assign slot_free = !mul_valid || mul_ready;
    assign can_issue = slot_free && !fifo_full
                       && (outstanding < CNT_W'(MAX_OUTSTAND)) && !reset;

    // rr_ptr names the requester favoured when both are valid.
    always_comb begin
        gnt_valid = 1'b0;
        gnt       = TAG_REQ0;
        if (req0_valid && req1_valid) begin
            gnt_valid = 1'b1;
            gnt       = rr_ptr;
        end else if (req0_valid) begin
            gnt_valid = 1'b1;
            gnt       = TAG_REQ0;
        end else if (req1_valid) begin
            gnt_valid = 1'b1;
            gnt       = TAG_REQ1;
        end
    end

    assign accept     = can_issue && gnt_valid;
    assign req0_ready = accept && (gnt == TAG_REQ0);
    assign req1_ready = accept && (gnt == TAG_REQ1);

    always_ff @(posedge clk) begin
        if (reset) begin
            mul_valid <= 1'b0;
            mul_xi    <= '0;
            mul_xq    <= '0;
            mul_yi    <= '0;
            mul_yq    <= '0;
            rr_ptr    <= TAG_REQ0;
        end else if (accept) begin
            mul_valid <= 1'b1;
            mul_xi    <= (gnt == TAG_REQ1) ? req1_xi : req0_xi;
            mul_xq    <= (gnt == TAG_REQ1) ? req1_xq : req0_xq;
            mul_yi    <= (gnt == TAG_REQ1) ? req1_yi : req0_yi;
            mul_yq    <= (gnt == TAG_REQ1) ? req1_yq : req0_yq;
            rr_ptr    <= ~gnt;
        end else if (slot_free) begin
            mul_valid <= 1'b0;
        end
    end

    cpx_arb_tag_fifo #(
        .DEPTH (MAX_OUTSTAND),
        .CW    (CNT_W)
    ) u_tag_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (accept),
        .push_tag (gnt),
        .pop      (pop),
        .head_tag (head_tag),
        .empty    (fifo_empty),
        .full     (fifo_full),
        .count    (outstanding)
    );

    // Products leave in issue order; the head tag picks the destination port.
    assign res0_valid = prod_valid && !fifo_empty && (head_tag == TAG_REQ0);
    assign res1_valid = prod_valid && !fifo_empty && (head_tag == TAG_REQ1);
    assign sel_ready  = (head_tag == TAG_REQ1) ? res1_ready : res0_ready;
    assign prod_ready = !fifo_empty && sel_ready && !reset;
    assign pop        = prod_valid && prod_ready;
    assign res_i      = prod_i;
    assign res_q      = prod_q;

`ifdef CPX_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_cnt0 <= '0;
            grant_cnt1 <= '0;
            stall_cnt  <= '0;
        end else begin
            if (accept && (gnt == TAG_REQ0)) grant_cnt0 <= grant_cnt0 + 32'd1;
            if (accept && (gnt == TAG_REQ1)) grant_cnt1 <= grant_cnt1 + 32'd1;
            if (mul_valid && !mul_ready)     stall_cnt  <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cpx_multiply_arbiter.sv
// Directed bench for cpx_multiply_arbiter with a simple valid/ready complex-multiplier model.
module tb_cpx_multiply_arbiter;

    localparam int unsigned XB = 12;
    localparam int unsigned YB = 12;
    localparam int unsigned OB = 25;

    typedef struct {
        int xi;
        int xq;
        int yi;
        int yq;
    } op_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid = 1'b0, req1_valid = 1'b0;
    logic          req0_ready, req1_ready;
    logic [XB-1:0] req0_xi = '0, req0_xq = '0, req1_xi = '0, req1_xq = '0;
    logic [YB-1:0] req0_yi = '0, req0_yq = '0, req1_yi = '0, req1_yq = '0;
    logic          mul_valid;
    logic          mul_ready = 1'b1;
    logic [XB-1:0] mul_xi, mul_xq;
    logic [YB-1:0] mul_yi, mul_yq;
    logic          prod_valid = 1'b0;
    logic          prod_ready;
    logic [OB-1:0] prod_i = '0, prod_q = '0;
    logic          res0_valid, res1_valid;
    logic          res0_ready = 1'b1, res1_ready = 1'b1;
    logic [OB-1:0] res_i, res_q;
`ifdef CPX_ARB_STATS_EN
    logic [31:0]   grant_cnt0, grant_cnt1, stall_cnt;
`endif

    int  nchk = 0;
    int  nfail = 0;
    op_t op0 [16];
    op_t op1 [16];
    int  i0, i1, acc;
    int  glog [$];
    int  r0_i [$], r0_q [$], r1_i [$], r1_q [$];
    int  res1_cnt = 0;
    int  stall_cycles = 0;
    logic toggle_en = 1'b0;
    int  mq_i [$], mq_q [$];

    cpx_multiply_arbiter #(
        .X_BITS (XB), .Y_BITS (YB), .OUT_BITS (OB), .MAX_OUTSTAND (8)
    ) dut (
        .clk (clk), .reset (reset),
        .req0_valid (req0_valid), .req0_ready (req0_ready),
        .req0_xi (req0_xi), .req0_xq (req0_xq), .req0_yi (req0_yi), .req0_yq (req0_yq),
        .req1_valid (req1_valid), .req1_ready (req1_ready),
        .req1_xi (req1_xi), .req1_xq (req1_xq), .req1_yi (req1_yi), .req1_yq (req1_yq),
        .mul_valid (mul_valid), .mul_ready (mul_ready),
        .mul_xi (mul_xi), .mul_xq (mul_xq), .mul_yi (mul_yi), .mul_yq (mul_yq),
        .prod_valid (prod_valid), .prod_ready (prod_ready),
        .prod_i (prod_i), .prod_q (prod_q),
        .res0_valid (res0_valid), .res0_ready (res0_ready),
        .res1_valid (res1_valid), .res1_ready (res1_ready),
        .res_i (res_i), .res_q (res_q)
`ifdef CPX_ARB_STATS_EN
        , .grant_cnt0 (grant_cnt0), .grant_cnt1 (grant_cnt1), .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Multiplier stand-in: accepts on mul handshake, presents products in order.
    always @(posedge clk) begin
        if (reset) begin
            mq_i.delete();
            mq_q.delete();
            prod_valid <= 1'b0;
        end else begin
            if (prod_valid && prod_ready) begin
                void'(mq_i.pop_front());
                void'(mq_q.pop_front());
            end
            if (mul_valid && mul_ready) begin
                mq_i.push_back(int'($signed(mul_xi)) * int'($signed(mul_yi))
                             - int'($signed(mul_xq)) * int'($signed(mul_yq)));
                mq_q.push_back(int'($signed(mul_xi)) * int'($signed(mul_yq))
                             + int'($signed(mul_xq)) * int'($signed(mul_yi)));
            end
            prod_valid <= (mq_i.size() != 0);
            prod_i     <= (mq_i.size() != 0) ? OB'(mq_i[0]) : '0;
            prod_q     <= (mq_q.size() != 0) ? OB'(mq_q[0]) : '0;
        end
    end

    always @(posedge clk) mul_ready <= toggle_en ? ~mul_ready : 1'b1;

    // Result collector.
    always @(posedge clk) begin
        if (!reset) begin
            if (res0_valid && res0_ready) begin
                r0_i.push_back(int'($signed(res_i)));
                r0_q.push_back(int'($signed(res_q)));
            end
            if (res1_valid && res1_ready) begin
                r1_i.push_back(int'($signed(res_i)));
                r1_q.push_back(int'($signed(res_q)));
            end
            if (res1_valid) res1_cnt++;
        end
    end

    // Issue register must hold its operands across a multiplier stall.
    logic          stall_prev = 1'b0;
    logic [XB-1:0] s_xi, s_xq;
    logic [YB-1:0] s_yi, s_yq;
    always @(posedge clk) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("stall_hold_valid", mul_valid, 1);
                check("stall_hold_xi", mul_xi, s_xi);
                check("stall_hold_xq", mul_xq, s_xq);
                check("stall_hold_yi", mul_yi, s_yi);
                check("stall_hold_yq", mul_yq, s_yq);
            end
            stall_prev = mul_valid && !mul_ready;
            if (stall_prev) begin
                stall_cycles++;
                s_xi = mul_xi; s_xq = mul_xq; s_yi = mul_yi; s_yq = mul_yq;
            end
        end
    end

    task automatic clear_state();
        i0 = 0; i1 = 0; acc = 0; res1_cnt = 0; stall_cycles = 0;
        glog.delete();
        r0_i.delete(); r0_q.delete(); r1_i.delete(); r1_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_state();
    endtask

    // Offer up to n0/n1 operand pairs, logging every grant; stops after max_cyc cycles.
    task automatic run(input int n0, input int n1, input int max_cyc);
        for (int c = 0; c < max_cyc && (i0 < n0 || i1 < n1); c++) begin
            req0_valid = (i0 < n0);
            req1_valid = (i1 < n1);
            req0_xi = 12'(op0[i0].xi); req0_xq = 12'(op0[i0].xq);
            req0_yi = 12'(op0[i0].yi); req0_yq = 12'(op0[i0].yq);
            req1_xi = 12'(op1[i1].xi); req1_xq = 12'(op1[i1].xq);
            req1_yi = 12'(op1[i1].yi); req1_yq = 12'(op1[i1].yq);
            @(negedge clk);
            if (req0_valid && req0_ready) begin glog.push_back(0); i0++; acc++; end
            if (req1_valid && req1_ready) begin glog.push_back(1); i1++; acc++; end
            @(posedge clk);
            #1;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag, input int n0, input int n1);
        int c;
        c = 0;
        while ((r0_i.size() < n0 || r1_i.size() < n1) && c < 200) begin
            @(posedge clk);
            c++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({tag, "_count0"}, r0_i.size(), n0);
        check({tag, "_count1"}, r1_i.size(), n1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b1;
        @(negedge clk);
        check("rst_mul_valid", mul_valid, 0);
        check("rst_mul_xi", mul_xi, 0);
        check("rst_req0_ready", req0_ready, 0);
        check("rst_res0_valid", res0_valid, 0);
        req0_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        clear_state();

        // T1: single req0 transaction
        req0_valid = 1'b1;
        req0_xi = 12'(3); req0_xq = 12'(4); req0_yi = 12'(5); req0_yq = 12'(-2);
        @(negedge clk);
        check("t1_req0_ready", req0_ready, 1);
        check("t1_req1_ready", req1_ready, 0);
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        check("t1_mul_valid", mul_valid, 1);
        check("t1_mul_xi", int'($signed(mul_xi)), 3);
        check("t1_mul_yq", int'($signed(mul_yq)), -2);
        wait_res("t1", 1, 0);
        check("t1_res_i", r0_i[0], 23);
        check("t1_res_q", r0_q[0], 14);
        check("t1_res1_never", res1_cnt, 0);
`ifdef CPX_ARB_STATS_EN
        check("t1_grant_cnt0", grant_cnt0, 1);
        check("t1_grant_cnt1", grant_cnt1, 0);
`endif

        // T2: both requesters valid every cycle, 8 pairs each
        do_reset();
        for (int k = 0; k < 16; k++) begin
            op0[k] = '{xi: k, xq: 0, yi: 1, yq: 1};
            op1[k] = '{xi: k, xq: 1, yi: 2, yq: 0};
        end
        run(8, 8, 40);
        check("t2_grants", glog.size(), 16);
        for (int k = 0; k < 16; k++) check("t2_grant_order", glog[k], k % 2);
        wait_res("t2", 8, 8);
        for (int k = 0; k < 8; k++) begin
            check("t2_r0_i", r0_i[k], k);
            check("t2_r0_q", r0_q[k], k);
            check("t2_r1_i", r1_i[k], 2 * k);
            check("t2_r1_q", r1_q[k], 2);
        end

        // T3: blocked req1 return port; issue must stop at 8 in flight
        do_reset();
        for (int k = 0; k < 16; k++) begin
            op0[k] = '{xi: k + 1, xq: 0, yi: 3, yq: 0};
            op1[k] = '{xi: 0, xq: k + 1, yi: 1, yq: 0};
        end
        res1_ready = 1'b0;
        run(0, 3, 10);
        run(10, 3, 30);
        check("t3_accepts", acc, 8);
        check("t3_req0_issued", i0, 5);
        req0_valid = 1'b1;
        req0_xi = 12'(op0[5].xi); req0_yi = 12'(op0[5].yi);
        @(negedge clk);
        check("t3_full_req0_ready", req0_ready, 0);
        check("t3_blocked_res1_valid", res1_valid, 1);
        check("t3_blocked_res0_valid", res0_valid, 0);
        check("t3_blocked_prod_ready", prod_ready, 0);
        @(posedge clk);
        #1;
        res1_ready = 1'b1;
        run(10, 3, 60);
        wait_res("t3", 10, 3);
        for (int k = 0; k < 10; k++) check("t3_r0_i", r0_i[k], 3 * k + 3);
        for (int k = 0; k < 3; k++) begin
            check("t3_r1_i", r1_i[k], 0);
            check("t3_r1_q", r1_q[k], k + 1);
        end

        // T4: mul_ready toggling
        do_reset();
        for (int k = 0; k < 16; k++) op0[k] = '{xi: k + 1, xq: k + 2, yi: 1, yq: -1};
        toggle_en = 1'b1;
        run(6, 0, 40);
        wait_res("t4", 6, 0);
        toggle_en = 1'b0;
        check("t4_stalls_seen", longint'(stall_cycles > 0), 1);
`ifdef CPX_ARB_STATS_EN
        check("t4_stall_cnt", stall_cnt, stall_cycles);
`endif
        for (int k = 0; k < 6; k++) begin
            check("t4_r0_i", r0_i[k], 2 * k + 3);
            check("t4_r0_q", r0_q[k], 1);
        end

        // T5: reset with 5 products in flight
        do_reset();
        for (int k = 0; k < 16; k++) begin
            op0[k] = '{xi: k + 1, xq: 0, yi: 3, yq: 0};
            op1[k] = '{xi: 0, xq: k + 1, yi: 1, yq: 0};
        end
        res0_ready = 1'b0;
        run(5, 0, 20);
        check("t5_inflight", acc, 5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("t5_rst_mul_valid", mul_valid, 0);
        check("t5_rst_res0_valid", res0_valid, 0);
        check("t5_rst_res1_valid", res1_valid, 0);
        reset = 1'b0;
        clear_state();
        run(10, 2, 30);
        check("t5_first_grant", glog[0], 0);
        check("t5_accepts", acc, 8);
        res0_ready = 1'b1;
        run(10, 2, 60);
        wait_res("t5", 10, 2);
        check("t5_r0_first", r0_i[0], 3);
        check("t5_r0_last", r0_i[9], 30);
        check("t5_r1_first_q", r1_q[0], 1);

        // T6: full-scale negative operands
        do_reset();
        op0[0] = '{xi: -2048, xq: -2048, yi: -2048, yq: -2048};
        op0[1] = '{xi: -2048, xq: -2048, yi: 2047, yq: -2048};
        op1[0] = '{xi: -2048, xq: -2048, yi: -2048, yq: 2047};
        run(2, 1, 20);
        wait_res("t6", 2, 1);
        check("t6_r0a_i", r0_i[0], 0);
        check("t6_r0a_q", r0_q[0], 8388608);
        check("t6_r0b_i", r0_i[1], -8386560);
        check("t6_r0b_q", r0_q[1], 2048);
        check("t6_r1_i", r1_i[0], 8386560);
        check("t6_r1_q", r1_q[0], 2048);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
        $finish;
    end

endmodule
